// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_CMP  = 4'd5,
    OP_MOV  = 4'd6,
    OP_SLL  = 4'd8,
    OP_SLR  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_MUL  = 4'd12,
    OP_DIVU = 4'd13
  } alu_op_e;

  // Bit positions inside the {S,Z,C,V} flag register
  localparam int unsigned FLG_S = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic [3:0] mk_flags(input logic s, input logic z, input logic c,
                                          input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_S] = s;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one bit per cycle.
// lo/hi present the result of the current step, so they hold the final value while done=1.
module iter_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH);

  // hi_q: accumulator / partial remainder; lo_q: multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, div_q;
  logic [WIDTH:0]   sum, shifted, diff;

  assign dbz  = is_div && (a == '0);
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  // One iteration step of either algorithm
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      // diff MSB set means the trial subtraction borrowed: restore
      if (!diff[WIDTH]) begin
        hi = diff[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand latch on start, then WIDTH iteration steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= is_div ? b : a;
      opnd_q <= is_div ? a : b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      div_q  <= is_div;
    end else if (busy_q) begin
      hi_q  <= hi;
      lo_q  <= lo;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift, iterative MUL/DIVU, SZCV flag register.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             wr_en,
  output logic [3:0]       flags
);

  state_e           state;
  alu_op_e          op_e;
  logic             accept, is_iter, busy_div;
  logic             md_done, md_dbz;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] res_c, hi_c, rl;
  logic             c_c, v_c, upd_c, wr_c;
  logic [WIDTH:0]   add_r, sub_r, sl, sr;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // Divide by zero is resolved in the single-cycle path
  assign is_iter   = (op_e == OP_MUL) || ((op_e == OP_DIVU) && !md_dbz);

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_iter),
    .is_div(op_e == OP_DIVU),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi),
    .dbz   (md_dbz)
  );

  // Log-stage barrel shifter; extra bit on each shift vector catches the last bit shifted out
  always_comb begin
    sl = {1'b0, b};
    sr = {b, 1'b0};
    rl = b;
    for (int k = 0; k < SHW; k++) begin
      if (shamt[k]) begin
        sl = sl << (1 << k);
        if (op_e == OP_SRA) sr = $unsigned($signed(sr) >>> (1 << k));
        else                sr = sr >> (1 << k);
        rl = (rl << (1 << k)) | (rl >> (WIDTH - (1 << k)));
      end
    end
  end

  // Single-cycle result, carry/overflow and flag-update decode
  always_comb begin
    add_r = {1'b0, b} + {1'b0, a};
    sub_r = {1'b0, b} - {1'b0, a};
    res_c = '0;
    hi_c  = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    upd_c = 1'b1;
    wr_c  = 1'b1;
    case (op_e)
      OP_ADD: begin
        res_c = add_r[WIDTH-1:0];
        c_c   = add_r[WIDTH];
        v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != b[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_c = sub_r[WIDTH-1:0];
        c_c   = sub_r[WIDTH];
        v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != b[WIDTH-1]);
        wr_c  = (op_e != OP_CMP);
      end
      OP_AND: res_c = b & a;
      OP_OR:  res_c = b | a;
      OP_XOR: res_c = b ^ a;
      OP_MOV: begin
        res_c = b;
        upd_c = 1'b0;
      end
      OP_SLL: begin
        res_c = sl[WIDTH-1:0];
        c_c   = sl[WIDTH];
      end
      OP_SLR: res_c = rl;
      OP_SRL, OP_SRA: begin
        res_c = sr[WIDTH:1];
        c_c   = sr[0];
      end
      OP_DIVU: begin
        res_c = '1;
        hi_c  = b;
        v_c   = 1'b1;
      end
      default: upd_c = 1'b0;
    endcase
  end

  // Control FSM with registered result, writeback qualifier and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_div  <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      wr_en     <= 1'b0;
      flags     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_iter) begin
              state    <= BUSY;
              busy_div <= (op_e == OP_DIVU);
            end else begin
              state     <= DONE;
              result    <= res_c;
              result_hi <= hi_c;
              wr_en     <= wr_c;
              if (upd_c) flags <= mk_flags(res_c[WIDTH-1], res_c == '0, c_c, v_c);
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            result    <= md_lo;
            result_hi <= md_hi;
            wr_en     <= 1'b1;
            flags     <= mk_flags(md_lo[WIDTH-1], md_lo == '0,
                                  !busy_div && (md_hi != '0), !busy_div && (md_hi != '0));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed bench for seq_alu_unit (WIDTH=16) with a cycle-level reference model.
module tb_seq_alu_unit;

  localparam int W = 16;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] CMP = 4'd5, MOV = 4'd6, BAD = 4'd7, SLL = 4'd8, SLR = 4'd9;
  localparam logic [3:0] SRL = 4'd10, SRA = 4'd11, MUL = 4'd12, DIVU = 4'd13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  shamt = '0;
  logic        in_ready, out_valid, wr_en;
  logic [15:0] result, result_hi;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_alu_unit #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .wr_en    (wr_en),
    .flags    (flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one operation, straight from the opcode table
  task automatic model_eval(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                            input logic [3:0] s, input logic [3:0] fl,
                            output logic [15:0] r, output logic [15:0] h,
                            output logic [3:0] f, output logic w, output logic it);
    logic        c, v, upd;
    logic [31:0] t;
    int          n;
    n = int'(s);
    c = 1'b0; v = 1'b0; upd = 1'b1; h = '0; r = '0; it = 1'b0;
    w = (o != CMP);
    case (o)
      ADD: begin
        t = 32'(x) + 32'(y);
        r = t[15:0];
        c = (t > 32'hFFFF);
        v = (x[15] == y[15]) && (r[15] != y[15]);
      end
      SUB, CMP: begin
        r = y - x;
        c = (y < x);
        v = (x[15] != y[15]) && (r[15] != y[15]);
      end
      AND_: r = x & y;
      OR_:  r = x | y;
      XOR_: r = x ^ y;
      MOV: begin r = y; upd = 1'b0; end
      SLL: begin t = 32'(y) << n; r = t[15:0]; c = t[16]; end
      SLR: begin t = {y, y} << n; r = t[31:16]; end
      SRL: begin t = {y, 16'h0} >> n; r = t[31:16]; c = t[15]; end
      SRA: begin t = $unsigned($signed({y, 16'h0}) >>> n); r = t[31:16]; c = t[15]; end
      MUL: begin
        t = 32'(x) * 32'(y);
        r = t[15:0]; h = t[31:16]; c = (h != 0); v = c; it = 1'b1;
      end
      DIVU: begin
        if (x == 0) begin r = 16'hFFFF; h = y; v = 1'b1; end
        else begin r = y / x; h = y % x; it = 1'b1; end
      end
      default: upd = 1'b0;
    endcase
    f = upd ? {r[15], (r == 16'h0), c, v} : fl;
  endtask

  // Model state: a pending long op counts down, a completed result waits for out_ready
  logic        m_pending, m_valid, m_wr;
  int          m_wait;
  logic [15:0] m_res, m_hi, m_pres, m_phi;
  logic [3:0]  m_flags, m_pflags;
  logic [15:0] t_r, t_h;
  logic [3:0]  t_f;
  logic        t_w, t_it, t_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0; m_valid <= 1'b0; m_wait <= 0; m_wr <= 1'b0;
      m_res <= '0; m_hi <= '0; m_flags <= '0;
      m_pres <= '0; m_phi <= '0; m_pflags <= '0;
    end else begin
      t_rdy = (!m_pending && !m_valid) || (m_valid && out_ready);
      if (in_valid && t_rdy) begin
        model_eval(op, a, b, shamt, m_flags, t_r, t_h, t_f, t_w, t_it);
        if (t_it) begin
          m_pending <= 1'b1; m_wait <= W; m_valid <= 1'b0;
          m_pres <= t_r; m_phi <= t_h; m_pflags <= t_f;
        end else begin
          m_valid <= 1'b1; m_res <= t_r; m_hi <= t_h; m_flags <= t_f; m_wr <= t_w;
        end
      end else if (m_pending) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_pending <= 1'b0; m_valid <= 1'b1;
          m_res <= m_pres; m_hi <= m_phi; m_flags <= m_pflags; m_wr <= 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("in_ready", in_ready, (!m_pending && !m_valid) || (m_valid && out_ready));
    check("out_valid", out_valid, m_valid);
    check("result", result, m_res);
    check("result_hi", result_hi, m_hi);
    check("wr_en", wr_en, m_wr);
    check("flags", flags, m_flags);
  end

  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic [3:0] s);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y; shamt = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; in_ready must stay low until the result appears
  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      check({name, "_busy_ready"}, in_ready, 0);
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 0);
    rst_n = 1'b1;

    send(ADD, 16'h0001, 16'h7FFF, 0);
    wait_result("add", 1);
    check("add_result", result, 16'h8000);
    check("add_flags", flags, 4'b1001);

    send(CMP, 16'd5, 16'd5, 0);
    wait_result("cmp", 1);
    check("cmp_wr_en", wr_en, 0);
    check("cmp_flags", flags, 4'b0100);

    send(MOV, 16'h1234, 16'h0000, 0);
    wait_result("mov", 1);
    check("mov_result", result, 16'h0000);
    check("mov_flags", flags, 4'b0100);
    check("mov_wr_en", wr_en, 1);

    send(SLL, 16'h0, 16'h8001, 4'd1);
    wait_result("sll", 1);
    check("sll_result", result, 16'h0002);
    check("sll_flags", flags, 4'b0010);

    send(SRA, 16'h0, 16'h8000, 4'd15);
    wait_result("sra", 1);
    check("sra_result", result, 16'hFFFF);
    check("sra_flags", flags, 4'b1000);

    send(BAD, 16'h0001, 16'h0002, 0);
    wait_result("bad", 1);
    check("bad_result", result, 16'h0000);
    check("bad_flags", flags, 4'b1000);

    send(SLR, 16'h0, 16'h8001, 4'd4);
    wait_result("slr", 1);
    check("slr_result", result, 16'h0018);
    check("slr_flags", flags, 4'b0000);

    send(SRL, 16'h0, 16'h00F1, 4'd4);
    wait_result("srl", 1);
    check("srl_result", result, 16'h000F);

    send(MUL, 16'h0002, 16'hFFFF, 0);
    wait_result("mul", 17);
    check("mul_lo", result, 16'hFFFE);
    check("mul_hi", result_hi, 16'h0001);
    check("mul_flags", flags, 4'b1011);

    send(DIVU, 16'd7, 16'd100, 0);
    wait_result("div", 17);
    check("div_q", result, 16'd14);
    check("div_r", result_hi, 16'd2);

    send(DIVU, 16'h0000, 16'h1234, 0);
    wait_result("dbz", 1);
    check("dbz_q", result, 16'hFFFF);
    check("dbz_r", result_hi, 16'h1234);
    check("dbz_flags", flags, 4'b1001);

    // Back-to-back single-cycle ops
    @(posedge clk); #1;
    in_valid = 1'b1; op = XOR_; a = 16'hF0F0; b = 16'hFF00;
    @(posedge clk); #1;
    op = OR_; a = 16'h000F; b = 16'h0F00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_result", result, 16'h0F0F);

    // Backpressure; a second request during the stall must be ignored
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = SUB; a = 16'd4; b = 16'd3;
    @(posedge clk); #1;
    op = ADD; a = 16'd1; b = 16'd1;
    repeat (5) begin
      @(negedge clk);
      check("bp_result", result, 16'hFFFF);
      check("bp_flags", flags, 4'b1010);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Reset in the middle of a multiply
    send(MUL, 16'd3, 16'd5, 0);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_result", result, 0);
    check("mrst_flags", flags, 0);
    check("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_no_result", out_valid, 0);

    send(ADD, 16'd2, 16'd3, 0);
    wait_result("post_rst_add", 1);
    check("post_rst_result", result, 16'd5);
    check("post_rst_flags", flags, 4'b0000);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
